// File: rtl/multiply_arbiter_if.sv
// multiply_arbiter_if: request/response bundle between issue ports and the shared multiplier arbiter
interface multiply_arbiter_if #(
  parameter int p_width   = 4,
  parameter int p_num_req = 4
);
  localparam int p_id_w = $clog2(p_num_req);
  logic [p_num_req-1:0]         req_valid_i;
  logic [p_num_req-1:0]         req_ready_o;
  logic [p_num_req*p_width-1:0] req_a_i;
  logic [p_num_req*p_width-1:0] req_b_i;
  logic [p_num_req-1:0]         req_a_signed_i;
  logic [p_num_req-1:0]         req_b_signed_i;
  logic                         resp_valid_o;
  logic                         resp_ready_i;
  logic [2*p_width-1:0]         resp_product_o;
  logic [p_id_w-1:0]            resp_id_o;
  modport master (
    output req_valid_i, req_a_i, req_b_i, req_a_signed_i, req_b_signed_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_product_o, resp_id_o
  );
  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_a_signed_i, req_b_signed_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_product_o, resp_id_o
  );
endinterface

// File: rtl/multiply_arbiter.sv
// multiply_arbiter: round-robin sharing of one signed/unsigned multiplier with a registered tagged response
module multiply_arbiter #(
  parameter int p_width   = 4,
  parameter int p_num_req = 4
) (
  input logic clk_i,
  input logic reset_i,
  multiply_arbiter_if.slave bus
);
  localparam int p_id_w = $clog2(p_num_req);
  logic [p_id_w-1:0] ptr, grant;
  logic [2*p_num_req-1:0] dbl;
  logic [p_num_req-1:0] rot;
  logic any, can_accept, accept;
  logic [p_width-1:0] a, b;
  logic sa, sb;
  logic [2*p_width-1:0] ea, eb, product;
  // rotate so bit 0 is the requester at ptr; lowest set bit wins
  assign dbl = {bus.req_valid_i, bus.req_valid_i} >> ptr;
  assign rot = dbl[p_num_req-1:0];
  always_comb begin
    grant = ptr;
    any = 1'b0;
    for (int i = p_num_req - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant = p_id_w'(int'(ptr) + i >= p_num_req ? int'(ptr) + i - p_num_req : int'(ptr) + i);
        any = 1'b1;
      end
    end
  end
  assign can_accept = !bus.resp_valid_o || bus.resp_ready_i;
  assign accept = any && can_accept && !reset_i;
  assign bus.req_ready_o = accept ? p_num_req'(1) << grant : '0;
  always_comb begin
    a = '0;
    b = '0;
    sa = 1'b0;
    sb = 1'b0;
    for (int i = 0; i < p_num_req; i++) begin
      if (grant == p_id_w'(i)) begin
        a = bus.req_a_i[i*p_width +: p_width];
        b = bus.req_b_i[i*p_width +: p_width];
        sa = bus.req_a_signed_i[i];
        sb = bus.req_b_signed_i[i];
      end
    end
  end
  // low 2*p_width bits of the extended product are exact for every sign mix
  assign ea = {{p_width{sa & a[p_width-1]}}, a};
  assign eb = {{p_width{sb & b[p_width-1]}}, b};
  assign product = ea * eb;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus.resp_valid_o <= 1'b0;
      bus.resp_product_o <= '0;
      bus.resp_id_o <= '0;
      ptr <= '0;
    end else if (accept) begin
      bus.resp_valid_o <= 1'b1;
      bus.resp_product_o <= product;
      bus.resp_id_o <= grant;
      ptr <= grant == p_id_w'(p_num_req - 1) ? '0 : grant + 1'b1;
    end else if (bus.resp_ready_i) begin
      bus.resp_valid_o <= 1'b0;
    end
  end
endmodule
